// File: rtl/eth_sw_pkg.sv
// eth_sw_pkg: shared types and port indices for the switch scheduler
package eth_sw_pkg;
  typedef struct packed {
    logic        eop;
    logic        sop;
    logic [31:0] data;
  } fifo_word_t;
  typedef enum logic [1:0] {IDLE, REQ, XFER} in_state_t;
  localparam int PORT_A = 0;
  localparam int PORT_B = 1;
endpackage

// File: rtl/eth_sw_sched_if.sv
// eth_sw_sched_if: ingress FIFO, egress and drop-counter signals of the scheduler
interface eth_sw_sched_if #(
  parameter int DROP_CNT_W = 16
);
  logic                  inEmptyA, inEmptyB;
  logic [33:0]           inRdDataA, inRdDataB;
  logic                  inRdEnA, inRdEnB;
  logic                  outStallA, outStallB;
  logic [31:0]           outDataA, outDataB;
  logic                  outSopA, outEopA, outValidA;
  logic                  outSopB, outEopB, outValidB;
  logic [DROP_CNT_W-1:0] dropCntA, dropCntB;
  modport master (
    output inEmptyA, inEmptyB, inRdDataA, inRdDataB, outStallA, outStallB,
    input  inRdEnA, inRdEnB, outDataA, outDataB, outSopA, outEopA, outValidA,
    input  outSopB, outEopB, outValidB, dropCntA, dropCntB
  );
  modport slave (
    input  inEmptyA, inEmptyB, inRdDataA, inRdDataB, outStallA, outStallB,
    output inRdEnA, inRdEnB, outDataA, outDataB, outSopA, outEopA, outValidA,
    output outSopB, outEopB, outValidB, dropCntA, dropCntB
  );
endinterface

// File: rtl/eth_rr_arb2.sv
// eth_rr_arb2: two-requester round-robin arbiter, locked from grant until release
module eth_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_release,
  output logic [1:0] o_gnt
);
  logic r_busy, r_ptr;
  always_comb o_gnt = r_busy ? 2'b00 : i_req == 2'b11 ? (r_ptr ? 2'b10 : 2'b01) : i_req;
  // busy stays set through the release cycle, so no grant can coincide with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_ptr  <= 1'b0;
    end else if (|o_gnt) begin
      r_busy <= 1'b1;
      r_ptr  <= !o_gnt[1];
    end else if (i_release) begin
      r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/eth_sw_sched.sv
// eth_sw_sched: per-input packet FSMs, per-output round-robin arbitration and registered egress
module eth_sw_sched
  import eth_sw_pkg::*;
#(
  parameter logic [31:0] PORTA_ADDR = 32'hABCD,
  parameter logic [31:0] PORTB_ADDR = 32'hBEEF,
  parameter int          DROP_CNT_W = 16
) (
  input logic           clk,
  input logic           reset,
  eth_sw_sched_if.slave bus
);
  fifo_word_t            w_head [2];
  in_state_t             r_state [2];
  in_state_t             w_next [2];
  logic [1:0]            w_gnt [2];
  logic [DROP_CNT_W-1:0] r_drop [2];
  logic [1:0]            w_empty, w_stall, w_pop, w_drop, w_fwd, w_last, w_granted, r_dest;
  assign w_head[0] = bus.inRdDataA;
  assign w_head[1] = bus.inRdDataB;
  assign w_empty   = {bus.inEmptyB, bus.inEmptyA};
  assign w_stall   = {bus.outStallB, bus.outStallA};
  always_ff @(posedge clk) begin
    if (reset) r_state <= '{IDLE, IDLE};
    else r_state <= w_next;
  end
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_next[i] = r_state[i] == IDLE ? (!w_empty[i] && w_head[i].sop ? REQ : IDLE) :
                  r_state[i] == REQ  ? (w_granted[i] ? XFER : REQ) :
                  (w_last[i] ? IDLE : XFER);
    end
  end
  // IDLE pops only headless words; XFER pops toward the locked output unless it stalls
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_granted[i] = w_gnt[r_dest[i]][i];
      w_pop[i]     = !reset && !w_empty[i] &&
                     (r_state[i] == IDLE ? !w_head[i].sop :
                      r_state[i] == XFER && !w_stall[r_dest[i]]);
      w_drop[i]    = r_state[i] == IDLE && w_pop[i];
      w_fwd[i]     = r_state[i] == XFER && w_pop[i];
      w_last[i]    = w_fwd[i] && w_head[i].eop;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dest <= '0;
      r_drop <= '{default: '0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_state[i] == IDLE && !w_empty[i] && w_head[i].sop)
          r_dest[i] <= w_head[i].data == PORTB_ADDR && PORTB_ADDR != PORTA_ADDR ? 1'(PORT_B) : 1'(PORT_A);
        if (w_drop[i] && !(&r_drop[i]))
          r_drop[i] <= r_drop[i] + 1'b1;
      end
    end
  end
  for (genvar p = 0; p < 2; p++) begin : g_out
    logic [1:0]  w_req, w_sel;
    logic        w_rel, r_valid, r_sop, r_eop;
    logic [31:0] r_data;
    fifo_word_t  w_word;
    assign w_req  = {r_state[1] == REQ && r_dest[1] == 1'(p), r_state[0] == REQ && r_dest[0] == 1'(p)};
    assign w_sel  = w_fwd & {r_dest[1] == 1'(p), r_dest[0] == 1'(p)};
    assign w_rel  = |(w_last & w_sel);
    assign w_word = w_sel[1] ? w_head[1] : w_head[0];
    eth_rr_arb2 u_arb (
      .clk       (clk),
      .rst       (reset),
      .i_req     (w_req),
      .i_release (w_rel),
      .o_gnt     (w_gnt[p])
    );
    // data holds its last value while idle; framing bits are valid-qualified
    always_ff @(posedge clk) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_sop   <= 1'b0;
        r_eop   <= 1'b0;
        r_data  <= '0;
      end else begin
        r_valid <= |w_sel;
        r_sop   <= |w_sel && w_word.sop;
        r_eop   <= |w_sel && w_word.eop;
        if (|w_sel) r_data <= w_word.data;
      end
    end
  end
  assign bus.inRdEnA   = w_pop[0];
  assign bus.inRdEnB   = w_pop[1];
  assign bus.outDataA  = g_out[0].r_data;
  assign bus.outSopA   = g_out[0].r_sop;
  assign bus.outEopA   = g_out[0].r_eop;
  assign bus.outValidA = g_out[0].r_valid;
  assign bus.outDataB  = g_out[1].r_data;
  assign bus.outSopB   = g_out[1].r_sop;
  assign bus.outEopB   = g_out[1].r_eop;
  assign bus.outValidB = g_out[1].r_valid;
  assign bus.dropCntA  = r_drop[0];
  assign bus.dropCntB  = r_drop[1];
endmodule

// File: tb/tb_eth_sw_sched.sv
// tb_eth_sw_sched: directed checks of routing, arbitration, stall, drop and reset
module tb_eth_sw_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush_a = 1'b0;
  logic        stall_a = 1'b0;
  logic        stall_b = 1'b0;
  int          tests = 0;
  int          fails = 0;
  logic [33:0] mem_a [64];
  logic [33:0] mem_b [64];
  int          ha = 0, ta = 0, hb = 0, tb_ = 0;
  logic [34:0] oa, ob;
  eth_sw_sched_if #(.DROP_CNT_W(16)) bus ();
  eth_sw_sched_if #(.DROP_CNT_W(2))  bus2 ();
  eth_sw_sched dut (.clk(clk), .reset(reset), .bus(bus));
  eth_sw_sched #(.DROP_CNT_W(2)) dut_sat (.clk(clk), .reset(reset), .bus(bus2));
  always #5 clk = ~clk;
  assign bus.inEmptyA   = (ha == ta);
  assign bus.inEmptyB   = (hb == tb_);
  assign bus.inRdDataA  = mem_a[ha % 64];
  assign bus.inRdDataB  = mem_b[hb % 64];
  assign bus.outStallA  = stall_a;
  assign bus.outStallB  = stall_b;
  assign bus2.inEmptyA  = bus.inEmptyA;
  assign bus2.inEmptyB  = bus.inEmptyB;
  assign bus2.inRdDataA = bus.inRdDataA;
  assign bus2.inRdDataB = bus.inRdDataB;
  assign bus2.outStallA = stall_a;
  assign bus2.outStallB = stall_b;
  assign oa = {bus.outValidA, bus.outSopA, bus.outEopA, bus.outDataA};
  assign ob = {bus.outValidB, bus.outSopB, bus.outEopB, bus.outDataB};
  // first-word-fall-through FIFO models; flush empties A while reset is held
  always @(posedge clk) begin
    if (flush_a) ha <= ta;
    else if (bus.inRdEnA) ha <= ha + 1;
    if (bus.inRdEnB) hb <= hb + 1;
  end
  function automatic logic [34:0] w(logic v, logic s, logic e, logic [31:0] d);
    return {v, s, e, d};
  endfunction
  function automatic logic [33:0] fw(logic e, logic s, logic [31:0] d);
    return {e, s, d};
  endfunction
  task automatic chk(string tag, logic [34:0] got, logic [34:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push_a(logic [33:0] x);
    mem_a[ta % 64] = x;
    ta++;
  endtask
  task automatic push_b(logic [33:0] x);
    mem_b[tb_ % 64] = x;
    tb_++;
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 3000 cycles");
    $fatal(1, "watchdog");
  end
  initial begin
    step(2);
    chk("rst_oa", oa, '0);
    chk("rst_ob", ob, '0);
    chk("rst_drop", 35'({bus.dropCntB, bus.dropCntA}), '0);
    reset = 1'b0;
    // single packet A -> B, first word 3 cycles after non-empty
    push_a(fw(0, 1, 'hBEEF)); push_a(fw(0, 0, 1)); push_a(fw(0, 0, 2)); push_a(fw(1, 0, 3));
    step(2); chk("t1_lat", ob, '0);
    step(1); chk("t1_sop", ob, w(1, 1, 0, 'hBEEF));
    step(1); chk("t1_w1", ob, w(1, 0, 0, 1));
    step(1); chk("t1_w2", ob, w(1, 0, 0, 2));
    step(1); chk("t1_eop", ob, w(1, 0, 1, 3));
    step(1); chk("t1_idle", ob, w(0, 0, 0, 3));
    chk("t1_oa", oa, '0);
    // contention after reset: pointer at A, A first
    reset = 1'b1;
    step(1); chk("t2_rst", ob, '0);
    reset = 1'b0;
    push_a(fw(0, 1, 'hABCD)); push_a(fw(0, 0, 'hA1)); push_a(fw(1, 0, 'hA2));
    push_b(fw(0, 1, 'hABCD)); push_b(fw(0, 0, 'hB1)); push_b(fw(1, 0, 'hB2));
    step(3); chk("t2_a_sop", oa, w(1, 1, 0, 'hABCD));
    step(1); chk("t2_a_w1", oa, w(1, 0, 0, 'hA1));
    step(1); chk("t2_a_eop", oa, w(1, 0, 1, 'hA2));
    step(1); chk("t2_gap", oa, w(0, 0, 0, 'hA2));
    step(1); chk("t2_b_sop", oa, w(1, 1, 0, 'hABCD));
    step(1); chk("t2_b_w1", oa, w(1, 0, 0, 'hB1));
    step(1); chk("t2_b_eop", oa, w(1, 0, 1, 'hB2));
    step(1); chk("t2_idle", oa, w(0, 0, 0, 'hB2));
    chk("t2_ob", ob, '0);
    // a lone grant to A moves the pointer to B, then B wins the next contention
    push_a(fw(1, 1, 'hABCD));
    step(3); chk("t3_one_word", oa, w(1, 1, 1, 'hABCD));
    step(1); chk("t3_one_idle", oa, w(0, 0, 0, 'hABCD));
    push_a(fw(0, 1, 'hABCD)); push_a(fw(1, 0, 'hC1));
    push_b(fw(0, 1, 'hABCD)); push_b(fw(1, 0, 'hD1));
    step(3); chk("t3_sop", oa, w(1, 1, 0, 'hABCD));
    step(1); chk("t3_b_first", oa, w(1, 0, 1, 'hD1));
    step(2); chk("t3_a_sop", oa, w(1, 1, 0, 'hABCD));
    step(1); chk("t3_a_eop", oa, w(1, 0, 1, 'hC1));
    step(1); chk("t3_idle", oa, w(0, 0, 0, 'hC1));
    // parallel: A -> B and B -> A with equal latency
    push_a(fw(0, 1, 'hBEEF)); push_a(fw(0, 0, 'h11)); push_a(fw(1, 0, 'h12));
    push_b(fw(0, 1, 'h1234)); push_b(fw(0, 0, 'h21)); push_b(fw(1, 0, 'h22));
    step(3); chk("t4_ob_sop", ob, w(1, 1, 0, 'hBEEF)); chk("t4_oa_sop", oa, w(1, 1, 0, 'h1234));
    step(1); chk("t4_ob_w1", ob, w(1, 0, 0, 'h11)); chk("t4_oa_w1", oa, w(1, 0, 0, 'h21));
    step(1); chk("t4_ob_eop", ob, w(1, 0, 1, 'h12)); chk("t4_oa_eop", oa, w(1, 0, 1, 'h22));
    step(1); chk("t4_ob_idle", ob, w(0, 0, 0, 'h12)); chk("t4_oa_idle", oa, w(0, 0, 0, 'h22));
    // two-cycle stall on output B mid-packet
    push_a(fw(0, 1, 'hBEEF)); push_a(fw(0, 0, 'h31)); push_a(fw(0, 0, 'h32));
    push_a(fw(0, 0, 'h33)); push_a(fw(1, 0, 'h34));
    step(3); chk("t5_sop", ob, w(1, 1, 0, 'hBEEF));
    step(1); chk("t5_w1", ob, w(1, 0, 0, 'h31));
    stall_b = 1'b1;
    step(1); chk("t5_stall1", ob, w(0, 0, 0, 'h31));
    step(1); chk("t5_stall2", ob, w(0, 0, 0, 'h31));
    stall_b = 1'b0;
    step(1); chk("t5_w2", ob, w(1, 0, 0, 'h32));
    step(1); chk("t5_w3", ob, w(1, 0, 0, 'h33));
    step(1); chk("t5_eop", ob, w(1, 0, 1, 'h34));
    step(1); chk("t5_idle", ob, w(0, 0, 0, 'h34));
    // headless words are dropped; the 2-bit instance saturates at 3
    push_a(fw(0, 0, 'hDD1)); push_a(fw(0, 0, 'hDD2)); push_a(fw(1, 0, 'hDD3));
    step(3); chk("t6_drop3", 35'(bus.dropCntA), 35'd3);
    chk("t6_empty", 35'(bus.inEmptyA), 35'd1);
    chk("t6_no_ob", ob, w(0, 0, 0, 'h34));
    chk("t6_no_oa", oa, w(0, 0, 0, 'h22));
    chk("t6_sat3", 35'(bus2.dropCntA), 35'd3);
    push_a(fw(0, 0, 'hE1)); push_a(fw(0, 0, 'hE2));
    step(2); chk("t6_drop5", 35'(bus.dropCntA), 35'd5);
    chk("t6_sat_hold", 35'(bus2.dropCntA), 35'd3);
    chk("t6_drop_b", 35'(bus.dropCntB), 35'd0);
    // reset in the middle of a transfer
    push_a(fw(0, 1, 'hBEEF)); push_a(fw(0, 0, 'h41)); push_a(fw(0, 0, 'h42)); push_a(fw(1, 0, 'h43));
    step(3); chk("t7_sop", ob, w(1, 1, 0, 'hBEEF));
    step(1); chk("t7_w1", ob, w(1, 0, 0, 'h41));
    reset = 1'b1;
    flush_a = 1'b1;
    step(1); chk("t7_rst_ob", ob, '0);
    chk("t7_rst_oa", oa, '0);
    chk("t7_rst_drop", 35'(bus.dropCntA), '0);
    chk("t7_rst_rden", 35'(bus.inRdEnA), '0);
    reset = 1'b0;
    flush_a = 1'b0;
    push_a(fw(0, 1, 'h1234)); push_a(fw(1, 0, 'h51));
    step(3); chk("t7_new_sop", oa, w(1, 1, 0, 'h1234));
    chk("t7_new_ob", ob, '0);
    step(1); chk("t7_new_eop", oa, w(1, 0, 1, 'h51));
    step(1); chk("t7_new_idle", oa, w(0, 0, 0, 'h51));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
